mem_access_ctrl: RTL and testbench

Memory-stage access controller placed directly upstream of the data memory, between the EX/MEM pipeline register and a variable-latency data memory port.
- Accepts one load/store per handshake.
- Generates the word address, byte enables and replicated store data.
- Holds the request until the memory acknowledges it.
- Sign- or zero-extends returned load data for the MEM/WB register.
- Drives the pipeline stall while an access is outstanding.

---
 rtl/mem_pkg.sv | 80 ++++++++
 rtl/load_ext.sv | 38 +++
 rtl/mem_access_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the memory-stage access controller.
package mem_pkg;

   localparam logic [1:0] ST_NONE = 2'b00;
   localparam logic [1:0] ST_SB   = 2'b01;
   localparam logic [1:0] ST_SH   = 2'b10;
   localparam logic [1:0] ST_SW   = 2'b11;

   localparam logic [2:0] LD_NONE = 3'b000;
   localparam logic [2:0] LD_LB   = 3'b001;
   localparam logic [2:0] LD_LBU  = 3'b010;
   localparam logic [2:0] LD_LH   = 3'b011;
   localparam logic [2:0] LD_LHU  = 3'b100;
   localparam logic [2:0] LD_LW   = 3'b101;

   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   // Byte ops keep the full offset, half ops keep bit 1, word ops keep none.
   function automatic logic [1:0] eff_off(
      input logic [1:0] st,
      input logic [2:0] ld,
      input logic [1:0] a
   );
      logic [1:0] off;
      off = 2'b00;
      if (st == ST_SB || ld == LD_LB || ld == LD_LBU)
         off = a;
      else if (st == ST_SH || ld == LD_LH || ld == LD_LHU)
         off = {a[1], 1'b0};
      return off;
   endfunction

   function automatic logic [3:0] store_be(
      input logic [1:0] st,
      input logic [1:0] off
   );
      logic [3:0] be;
      case (st)
         ST_SB:   be = 4'b0001 << off;
         ST_SH:   be = off[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] store_data(
      input logic [1:0]  st,
      input logic [31:0] wd
   );
      logic [31:0] d;
      case (st)
         ST_SB:   d = {4{wd[7:0]}};
         ST_SH:   d = {2{wd[15:0]}};
         default: d = wd;
      endcase
      return d;
   endfunction

   function automatic logic misaligned(
      input logic [1:0] st,
      input logic [2:0] ld,
      input logic [1:0] a
   );
      logic m;
      m = 1'b0;
      if (st == ST_SH || ld == LD_LH || ld == LD_LHU)
         m = a[0];
      else if (st == ST_SW || ld == LD_LW)
         m = (a != 2'b00);
      return m;
   endfunction

endpackage

// File: rtl/load_ext.sv
// Selects the addressed byte/half of a read word and sign/zero-extends it.
module load_ext
   import mem_pkg::*;
(
   input  logic [2:0]  i_load,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[7:0];
      unique case (i_off)
         2'd0: w_byte = i_rdata[7:0];
         2'd1: w_byte = i_rdata[15:8];
         2'd2: w_byte = i_rdata[23:16];
         2'd3: w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
      w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   always_comb begin
      o_data = 32'd0;
      case (i_load)
         LD_LB:   o_data = {{24{w_byte[7]}}, w_byte};
         LD_LBU:  o_data = {24'd0, w_byte};
         LD_LH:   o_data = {{16{w_half[15]}}, w_half};
         LD_LHU:  o_data = {16'd0, w_half};
         LD_LW:   o_data = i_rdata;
         default: o_data = 32'd0;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller between EX/MEM and the data memory port.
// Options: ALIGN_EXC_EN (misalignment exceptions), MEM_TIMEOUT_EN (ack timeout).
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_W = 32
`ifdef MEM_TIMEOUT_EN
   , parameter int TIMEOUT_CYC = 255
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_store,
   input  logic [2:0]        in_load,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [31:0]       in_wdata,
   input  logic [31:0]       in_pc,
   input  logic              flush,
   output logic              mem_req,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic              out_valid,
   output logic [31:0]       out_rdata,
   output logic [31:0]       out_pc,
`ifdef MEM_TIMEOUT_EN
   output logic              mem_timeout,
`endif
`ifdef ALIGN_EXC_EN
   output logic              out_exc,
   output logic [4:0]        out_exc_code,
`endif
   output logic              stall
);

   state_t              r_state;
   logic [2:0]          r_ld;
   logic [1:0]          r_off;
   logic [31:0]         r_pc;
   logic                r_in_ready;
   logic                r_stall;
   logic                r_mem_req;
   logic                r_mem_we;
   logic [3:0]          r_mem_be;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [31:0]         r_mem_wdata;
   logic                r_out_valid;
   logic [31:0]         r_out_rdata;
   logic                r_flushed;

   logic                w_st_op;
   logic [2:0]          w_ld;
   logic                w_mem_op;
   logic [1:0]          w_off;
   logic [31:0]         w_ext;
   logic                w_to;

   // A store wins over a simultaneous load, so the load field is dropped.
   assign w_st_op  = (in_store != ST_NONE);
   assign w_ld     = w_st_op ? LD_NONE : in_load;
   assign w_mem_op = w_st_op | (w_ld != LD_NONE);
   assign w_off    = eff_off(in_store, w_ld, in_addr[1:0]);

`ifdef MEM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] r_tcnt;
   logic          r_timeout;

   assign w_to        = (r_tcnt == TLAST) & ~mem_ack;
   assign mem_timeout = r_timeout;
`else
   assign w_to = 1'b0;
`endif

`ifdef ALIGN_EXC_EN
   logic       w_mis;
   logic       r_exc;
   logic [4:0] r_exc_code;

   assign w_mis        = misaligned(in_store, w_ld, in_addr[1:0]);
   assign out_exc      = r_exc;
   assign out_exc_code = r_exc_code;
`endif

   load_ext u_load_ext (
      .i_load  (r_ld),
      .i_off   (r_off),
      .i_rdata (mem_rdata),
      .o_data  (w_ext)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_ld        <= LD_NONE;
         r_off       <= 2'b00;
         r_pc        <= 32'd0;
         r_in_ready  <= 1'b1;
         r_stall     <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_be    <= 4'd0;
         r_mem_addr  <= '0;
         r_mem_wdata <= 32'd0;
         r_out_valid <= 1'b0;
         r_out_rdata <= 32'd0;
         r_flushed   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         r_tcnt      <= '0;
         r_timeout   <= 1'b0;
`endif
`ifdef ALIGN_EXC_EN
         r_exc       <= 1'b0;
         r_exc_code  <= 5'd0;
`endif
      end else begin
         unique case (r_state)
            IDLE: begin
               if (in_valid && !flush) begin
                  r_ld       <= w_ld;
                  r_off      <= w_off;
                  r_pc       <= in_pc;
                  r_flushed  <= 1'b0;
                  r_in_ready <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                  r_tcnt     <= '0;
`endif
`ifdef ALIGN_EXC_EN
                  if (w_mem_op && w_mis) begin
                     r_state     <= RESP;
                     r_out_valid <= 1'b1;
                     r_out_rdata <= 32'd0;
                     r_exc       <= 1'b1;
                     r_exc_code  <= w_st_op ? EXC_ADES : EXC_ADEL;
                  end else
`endif
                  if (w_mem_op) begin
                     r_state     <= BUSY;
                     r_stall     <= 1'b1;
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= w_st_op;
                     r_mem_be    <= store_be(in_store, w_off);
                     r_mem_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
                     r_mem_wdata <= store_data(in_store, in_wdata);
                  end else begin
                     r_state     <= RESP;
                     r_out_valid <= 1'b1;
                     r_out_rdata <= 32'd0;
                  end
               end
            end
            BUSY: begin
               if (flush)
                  r_flushed <= 1'b1;
`ifdef MEM_TIMEOUT_EN
               r_tcnt <= r_tcnt + 1'b1;
`endif
               // A flushed access still runs to the ack, it just reports nothing.
               if (mem_ack || w_to) begin
                  r_mem_req <= 1'b0;
                  r_stall   <= 1'b0;
                  if (r_flushed || flush) begin
                     r_state    <= IDLE;
                     r_in_ready <= 1'b1;
                     r_flushed  <= 1'b0;
                  end else begin
                     r_state     <= RESP;
                     r_out_valid <= 1'b1;
                     r_out_rdata <= w_to ? 32'd0 : w_ext;
`ifdef MEM_TIMEOUT_EN
                     r_timeout   <= w_to;
`endif
                  end
               end
            end
            RESP: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
`ifdef MEM_TIMEOUT_EN
               r_timeout   <= 1'b0;
`endif
`ifdef ALIGN_EXC_EN
               r_exc       <= 1'b0;
               r_exc_code  <= 5'd0;
`endif
            end
            default: begin
               r_state    <= IDLE;
               r_in_ready <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign stall     = r_stall;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_be    = r_mem_be;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign out_valid = r_out_valid & ~flush;
   assign out_rdata = r_out_rdata;
   assign out_pc    = r_pc;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: stores, loads, flush and reset cases.
module tb_mem_access_ctrl;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_store = 2'd0;
   logic [2:0]  in_load = 3'd0;
   logic [31:0] in_addr = 32'd0;
   logic [31:0] in_wdata = 32'd0;
   logic [31:0] in_pc = 32'd0;
   logic        flush = 1'b0;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        out_valid;
   logic [31:0] out_rdata;
   logic [31:0] out_pc;
   logic        stall;
`ifdef MEM_TIMEOUT_EN
   logic        mem_timeout;
`endif
`ifdef ALIGN_EXC_EN
   logic        out_exc;
   logic [4:0]  out_exc_code;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.ADDR_W(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_store     (in_store),
      .in_load      (in_load),
      .in_addr      (in_addr),
      .in_wdata     (in_wdata),
      .in_pc        (in_pc),
      .flush        (flush),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_be       (mem_be),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .out_valid    (out_valid),
      .out_rdata    (out_rdata),
      .out_pc       (out_pc),
`ifdef MEM_TIMEOUT_EN
      .mem_timeout  (mem_timeout),
`endif
`ifdef ALIGN_EXC_EN
      .out_exc      (out_exc),
      .out_exc_code (out_exc_code),
`endif
      .stall        (stall)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] st, input logic [2:0] ld,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] pc);
      chk("ready_before_issue", in_ready, 1);
      in_valid = 1'b1;
      in_store = st;
      in_load  = ld;
      in_addr  = a;
      in_wdata = wd;
      in_pc    = pc;
      tick();
      in_valid = 1'b0;
      in_store = ST_NONE;
      in_load  = LD_NONE;
   endtask

   task automatic do_load(input string tag, input logic [2:0] ld,
                          input logic [31:0] a, input logic [31:0] rd,
                          input int dly, input logic [31:0] exp_d,
                          input logic [31:0] exp_a, input logic [31:0] pc);
      issue(ST_NONE, ld, a, 32'h0, pc);
      chk({tag, "_addr"}, mem_addr, exp_a);
      chk({tag, "_be"}, mem_be, 4'b1111);
      chk({tag, "_we"}, mem_we, 0);
      for (int i = 0; i <= dly; i++) begin
         chk({tag, "_stall"}, stall, 1);
         chk({tag, "_req"}, mem_req, 1);
         chk({tag, "_nov"}, out_valid, 0);
         if (i == dly) begin
            mem_ack   = 1'b1;
            mem_rdata = rd;
         end
         tick();
      end
      mem_ack = 1'b0;
      chk({tag, "_ov"}, out_valid, 1);
      chk({tag, "_data"}, out_rdata, exp_d);
      chk({tag, "_pc"}, out_pc, pc);
      chk({tag, "_stall_off"}, stall, 0);
      chk({tag, "_req_off"}, mem_req, 0);
      tick();
      chk({tag, "_ov_off"}, out_valid, 0);
   endtask

   task automatic do_store(input string tag, input logic [1:0] st,
                           input logic [2:0] ld, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd, input logic [31:0] exp_a,
                           input logic [31:0] pc);
      issue(st, ld, a, wd, pc);
      chk({tag, "_req"}, mem_req, 1);
      chk({tag, "_we"}, mem_we, 1);
      chk({tag, "_be"}, mem_be, exp_be);
      chk({tag, "_wd"}, mem_wdata, exp_wd);
      chk({tag, "_addr"}, mem_addr, exp_a);
      chk({tag, "_nov"}, out_valid, 0);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk({tag, "_ov"}, out_valid, 1);
      chk({tag, "_rd0"}, out_rdata, 0);
      chk({tag, "_pc"}, out_pc, pc);
      tick();
      chk({tag, "_idle"}, in_ready, 1);
   endtask

   initial begin
      tick();
      tick();
      chk("rst_ready", in_ready, 1);
      chk("rst_req", mem_req, 0);
      chk("rst_ov", out_valid, 0);
      chk("rst_stall", stall, 0);
      chk("rst_rdata", out_rdata, 0);
      chk("rst_pc", out_pc, 0);
      chk("rst_be", mem_be, 0);
      chk("rst_addr", mem_addr, 0);
      reset = 1'b0;
      tick();

      // sb 0xAB at 0x13, ack on the first request cycle
      issue(ST_SB, LD_NONE, 32'h13, 32'h000000AB, 32'h100);
      chk("sb_req", mem_req, 1);
      chk("sb_be", mem_be, 4'b1000);
      chk("sb_addr", mem_addr, 32'h10);
      chk("sb_wd", mem_wdata, 32'hABABABAB);
      chk("sb_we", mem_we, 1);
      chk("sb_stall", stall, 1);
      chk("sb_busy_ready", in_ready, 0);
      chk("sb_nov", out_valid, 0);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("sb_ov", out_valid, 1);
      chk("sb_pc", out_pc, 32'h100);
      chk("sb_rd0", out_rdata, 0);
      chk("sb_req_off", mem_req, 0);
      chk("sb_resp_ready", in_ready, 0);
      tick();
      chk("sb_ov_off", out_valid, 0);
      chk("sb_idle", in_ready, 1);

      do_store("sh_mis", ST_SH, LD_NONE, 32'h03, 32'h1234ABCD,
               4'b1100, 32'hABCDABCD, 32'h0, 32'h110);
      do_store("sh_lo", ST_SH, LD_NONE, 32'h08, 32'h00005A5A,
               4'b0011, 32'h5A5A5A5A, 32'h8, 32'h114);
      do_store("sb_1", ST_SB, LD_NONE, 32'h21, 32'hFFFFFF55,
               4'b0010, 32'h55555555, 32'h20, 32'h118);
      do_store("sw", ST_SW, LD_NONE, 32'h105, 32'hDEADBEEF,
               4'b1111, 32'hDEADBEEF, 32'h104, 32'h11C);
      do_store("st_prec", ST_SB, LD_LW, 32'h0, 32'h00000077,
               4'b0001, 32'h77777777, 32'h0, 32'h120);

      do_load("lb", LD_LB, 32'h2, 32'h00800000, 3, 32'hFFFFFF80,
              32'h0, 32'h200);
      do_load("lbu", LD_LBU, 32'h2, 32'h00800000, 0, 32'h00000080,
              32'h0, 32'h204);
      do_load("lh", LD_LH, 32'h2, 32'h80011234, 0, 32'hFFFF8001,
              32'h0, 32'h208);
      do_load("lhu", LD_LHU, 32'h2, 32'h80011234, 1, 32'h00008001,
              32'h0, 32'h20C);
      do_load("lw", LD_LW, 32'h2, 32'h80011234, 0, 32'h80011234,
              32'h0, 32'h210);
      do_load("lb1", LD_LB, 32'h41, 32'h00007F00, 0, 32'h0000007F,
              32'h40, 32'h214);
      do_load("lh0", LD_LH, 32'h0, 32'h0000F00F, 2, 32'hFFFFF00F,
              32'h0, 32'h218);

      // non-memory op goes straight to RESP
      issue(ST_NONE, LD_NONE, 32'h55, 32'h0, 32'h300);
      chk("nop_ov", out_valid, 1);
      chk("nop_req", mem_req, 0);
      chk("nop_rd0", out_rdata, 0);
      chk("nop_pc", out_pc, 32'h300);
      tick();

      // flush in IDLE blocks acceptance
      in_valid = 1'b1;
      in_load  = LD_LW;
      flush    = 1'b1;
      tick();
      in_valid = 1'b0;
      in_load  = LD_NONE;
      flush    = 1'b0;
      chk("fi_req", mem_req, 0);
      chk("fi_ready", in_ready, 1);
      chk("fi_ov", out_valid, 0);

      // flush in BUSY: transaction completes silently
      issue(ST_NONE, LD_LW, 32'h40, 32'h0, 32'h400);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fb_req_held", mem_req, 1);
      chk("fb_addr_held", mem_addr, 32'h40);
      chk("fb_stall", stall, 1);
      mem_ack   = 1'b1;
      mem_rdata = 32'h12345678;
      tick();
      mem_ack = 1'b0;
      chk("fb_nov", out_valid, 0);
      chk("fb_req_off", mem_req, 0);
      chk("fb_ready", in_ready, 1);
      issue(ST_NONE, LD_NONE, 32'h0, 32'h0, 32'h404);
      chk("fb_next_ov", out_valid, 1);
      chk("fb_next_pc", out_pc, 32'h404);
      tick();

      // flush in RESP suppresses out_valid
      issue(ST_NONE, LD_NONE, 32'h0, 32'h0, 32'h500);
      flush = 1'b1;
      #1;
      chk("fr_nov", out_valid, 0);
      tick();
      flush = 1'b0;
      chk("fr_ready", in_ready, 1);
      chk("fr_ov_off", out_valid, 0);

      // reset in BUSY, then a stray ack
      issue(ST_NONE, LD_LW, 32'h80, 32'h0, 32'h600);
      chk("rb_req", mem_req, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rb_req_off", mem_req, 0);
      chk("rb_ready", in_ready, 1);
      mem_ack   = 1'b1;
      mem_rdata = 32'hCAFEF00D;
      tick();
      mem_ack = 1'b0;
      chk("rb_stray_ov", out_valid, 0);
      chk("rb_stray_req", mem_req, 0);
      chk("rb_stray_stall", stall, 0);
      tick();
      chk("rb_stray_ov2", out_valid, 0);

`ifdef ALIGN_EXC_EN
      issue(ST_SW, LD_NONE, 32'h06, 32'h0, 32'h700);
      chk("ae_req", mem_req, 0);
      chk("ae_ov", out_valid, 1);
      chk("ae_exc", out_exc, 1);
      chk("ae_code", out_exc_code, 5);
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
